// File: rtl/spi_buffered_if.sv
// Register-side bus of the buffered SPI master: TX push port, RX pop port, status flags.
// Handshake: tx_write pushes tx_data in the cycle it is high and is accepted only while
// tx_full is low; rx_read pops rx_data in the cycle it is high and takes effect only while
// rx_empty is low; both strobes are sampled on the rising raw_clk edge.
interface spi_buffered_if;
  logic [7:0] tx_data;
  logic       tx_write;
  logic       tx_full;
  logic [7:0] rx_data;
  logic       rx_read;
  logic       rx_empty;
  logic       rx_overflow;
  logic       clear_overflow;
  logic       busy;

  modport master (
    output tx_data, tx_write, rx_read, clear_overflow,
    input  tx_full, rx_data, rx_empty, rx_overflow, busy
  );

  modport slave (
    input  tx_data, tx_write, rx_read, clear_overflow,
    output tx_full, rx_data, rx_empty, rx_overflow, busy
  );
endinterface

// File: rtl/spi_buffered.sv
// Buffered SPI master (mode 0, MSB first) with TX/RX FIFOs and a programmable SCLK divider.
// Optional SPI_LOOPBACK_EN adds a loopback input that feeds mosi back into the receive path.
module spi_buffered #(
  parameter int DEPTH     = 4,
  parameter int DIV_WIDTH = 8
) (
  input  logic                 raw_clk,
  input  logic                 reset,
  spi_buffered_if.slave        bus,
  input  logic [DIV_WIDTH-1:0] divider,
  output logic                 sclk,
  output logic                 mosi,
  input  logic                 miso,
`ifdef SPI_LOOPBACK_EN
  input  logic                 loopback,
`endif
  output logic [2:0]           dbg_state
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {IDLE, LOAD, LOW, HIGH, DONE} state_t;
  state_t state, state_n;

  logic [7:0]           tx_mem [DEPTH];
  logic [AW-1:0]        tx_wr, tx_rd;
  logic [CW-1:0]        tx_count;
  logic                 tx_push, tx_pop;

  logic [7:0]           rx_mem [DEPTH];
  logic [AW-1:0]        rx_wr, rx_rd, rx_rd_nx;
  logic [CW-1:0]        rx_count, rx_count_n;
  logic                 rx_push_req, rx_push, rx_pop, ovf_set;
  logic [7:0]           rx_data_q, rx_head_n;

  logic [7:0]           tx_sh, rx_sh;
  logic [2:0]           bit_cnt;
  logic [DIV_WIDTH-1:0] div_q, half_cnt;
  logic                 half_done, rx_bit;
  logic                 sclk_q, mosi_q, ovf_q;

`ifdef SPI_LOOPBACK_EN
  assign rx_bit = loopback ? mosi_q : miso;
`else
  assign rx_bit = miso;
`endif

  assign tx_push     = bus.tx_write && (tx_count != CW'(DEPTH));
  assign tx_pop      = (state == LOAD);
  assign rx_push_req = (state == DONE);
  assign rx_pop      = bus.rx_read && (rx_count != '0);
  // A pop in the DONE cycle frees a slot, so a full FIFO can still take the new byte.
  assign rx_push     = rx_push_req && ((rx_count != CW'(DEPTH)) || rx_pop);
  assign ovf_set     = rx_push_req && !rx_push;
  assign rx_count_n  = rx_count + CW'(rx_push) - CW'(rx_pop);
  assign rx_rd_nx    = rx_rd + 1'b1;
  assign half_done   = (half_cnt == div_q);

  // rx_data is a register tracking the head the FIFO will have next cycle.
  always_comb begin
    rx_head_n = rx_data_q;
    if (rx_count_n != '0) begin
      if (rx_pop)
        rx_head_n = (rx_count > CW'(1)) ? rx_mem[rx_rd_nx] : rx_sh;
      else if (rx_count == '0)
        rx_head_n = rx_sh;
      else
        rx_head_n = rx_mem[rx_rd];
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (tx_count != '0) state_n = LOAD;
      LOAD: state_n = LOW;
      LOW:  if (half_done) state_n = HIGH;
      HIGH: if (half_done) state_n = (bit_cnt == 3'd7) ? DONE : LOW;
      DONE: state_n = (tx_count != '0) ? LOAD : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge raw_clk) begin
    if (tx_push) tx_mem[tx_wr] <= bus.tx_data;
    if (rx_push) rx_mem[rx_wr] <= rx_sh;
  end

  always_ff @(posedge raw_clk) begin
    if (reset) begin
      state     <= IDLE;
      tx_wr     <= '0;
      tx_rd     <= '0;
      tx_count  <= '0;
      rx_wr     <= '0;
      rx_rd     <= '0;
      rx_count  <= '0;
      rx_data_q <= '0;
      ovf_q     <= 1'b0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      bit_cnt   <= '0;
      div_q     <= '0;
      half_cnt  <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
    end else begin
      state <= state_n;
      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_pop)  tx_rd <= tx_rd + 1'b1;
      tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
      if (rx_push) rx_wr <= rx_wr + 1'b1;
      if (rx_pop)  rx_rd <= rx_rd_nx;
      rx_count  <= rx_count_n;
      rx_data_q <= rx_head_n;
      if (ovf_set)                 ovf_q <= 1'b1;
      else if (bus.clear_overflow) ovf_q <= 1'b0;

      case (state)
        LOAD: begin
          tx_sh    <= tx_mem[tx_rd];
          mosi_q   <= tx_mem[tx_rd][7];
          div_q    <= divider;
          bit_cnt  <= '0;
          half_cnt <= '0;
        end
        LOW: begin
          if (half_done) begin
            half_cnt <= '0;
            rx_sh    <= {rx_sh[6:0], rx_bit};
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        HIGH: begin
          if (half_done) begin
            half_cnt <= '0;
            if (bit_cnt != 3'd7) begin
              bit_cnt <= bit_cnt + 1'b1;
              tx_sh   <= {tx_sh[6:0], 1'b0};
              mosi_q  <= tx_sh[6];
            end
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        default: ;
      endcase
      if (state_n == IDLE) mosi_q <= 1'b0;
      sclk_q <= (state_n == HIGH);
    end
  end

  assign sclk            = sclk_q;
  assign mosi            = mosi_q;
  assign bus.tx_full     = (tx_count == CW'(DEPTH));
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_empty    = (rx_count == '0);
  assign bus.rx_overflow = ovf_q;
  assign bus.busy        = (tx_count != '0) || (state != IDLE);
  assign dbg_state       = state;
endmodule

// File: tb/tb_spi_buffered.sv
// Bench for spi_buffered: SPI slave model on the pins, transaction-level RX FIFO model,
// vector table for single bytes, hand sequences for FIFO/reset corners, randomized bursts.
module tb_spi_buffered;
  localparam int DEPTH = 4;

  logic       raw_clk, reset, sclk, mosi, miso;
  logic [7:0] divider;
  logic [2:0] dbg_state;
`ifdef SPI_LOOPBACK_EN
  logic       loopback;
`endif
  spi_buffered_if bus();

  spi_buffered #(.DEPTH(DEPTH), .DIV_WIDTH(8)) dut (
    .raw_clk(raw_clk), .reset(reset), .bus(bus), .divider(divider),
    .sclk(sclk), .mosi(mosi), .miso(miso),
`ifdef SPI_LOOPBACK_EN
    .loopback(loopback),
`endif
    .dbg_state(dbg_state)
  );

  initial begin
    raw_clk = 1'b0;
    forever #5 raw_clk = ~raw_clk;
  end

  int tests = 0;
  int fails = 0;
  int busy_cycles = 0;
  int total_rises = 0;

  logic [7:0] miso_src_q[$];
  logic [7:0] arrived_q[$];
  logic [7:0] mosi_obs_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] rx_model[$];
  bit         model_ovf;
  logic [7:0] last_rd;

  // Mode-0 slave: captures mosi on each sclk rise, presents the next miso bit after it.
  logic [7:0] slave_byte, mosi_shift;
  int         slave_idx;
  bit         slave_have;
  logic       sclk_prev;
  always @(posedge raw_clk) begin
    #2;
    if (reset) begin
      slave_idx  = 0;
      slave_have = 0;
      sclk_prev  = 1'b0;
      miso       = 1'b0;
    end else begin
      if (sclk && !sclk_prev) begin
        mosi_shift = {mosi_shift[6:0], mosi};
        slave_idx++;
        total_rises++;
        if (slave_idx == 8) begin
          mosi_obs_q.push_back(mosi_shift);
          arrived_q.push_back(slave_have ? slave_byte : 8'h00);
          slave_idx  = 0;
          slave_have = 0;
        end
      end
      sclk_prev = sclk;
      if (!slave_have && slave_idx == 0 && miso_src_q.size() > 0) begin
        slave_byte = miso_src_q.pop_front();
        slave_have = 1;
      end
      miso = slave_have ? slave_byte[7 - slave_idx] : 1'b0;
    end
  end

  always @(negedge raw_clk) if (bus.busy) busy_cycles++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    bus.tx_data  = b;
    bus.tx_write = 1'b1;
    @(negedge raw_clk);
    bus.tx_write = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    @(negedge raw_clk);
    while (bus.busy && n < bound) begin
      @(negedge raw_clk);
      n++;
    end
    check("wait_idle", bus.busy, 1'b0);
  endtask

  // Waits until the 8th sclk-high cycle of a divider=0 byte has been seen.
  task automatic wait_high8();
    int highs = 0;
    int n = 0;
    while (highs < 8 && n < 200) begin
      @(negedge raw_clk);
      if (sclk) highs++;
      n++;
    end
    check("wait_high8", highs, 8);
  endtask

  // RX FIFO reference: bytes the slave returned land in order until DEPTH, then are dropped.
  task automatic absorb();
    while (arrived_q.size() > 0) begin
      logic [7:0] b;
      b = arrived_q.pop_front();
      if (rx_model.size() < DEPTH) rx_model.push_back(b);
      else model_ovf = 1;
    end
  endtask

  task automatic read_rx();
    logic [7:0] e;
    if (rx_model.size() == 0) return;
    e = rx_model.pop_front();
    check("rx_empty_before_read", bus.rx_empty, 1'b0);
    check("rx_data", bus.rx_data, e);
    last_rd = e;
    bus.rx_read = 1'b1;
    @(negedge raw_clk);
    bus.rx_read = 1'b0;
  endtask

  task automatic drain();
    while (rx_model.size() > 0) read_rx();
    check("rx_empty_after_drain", bus.rx_empty, 1'b1);
  endtask

  task automatic check_mosi(input string name);
    check({name, "_mosi_count"}, mosi_obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && mosi_obs_q.size() > 0)
      check({name, "_mosi_byte"}, mosi_obs_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    mosi_obs_q.delete();
  endtask

  task automatic pulse_clear();
    bus.clear_overflow = 1'b1;
    @(negedge raw_clk);
    bus.clear_overflow = 1'b0;
  endtask

  typedef struct {
    logic [7:0] div;
    logic [7:0] tx;
    logic [7:0] miso_b;
    logic [7:0] exp_rx;
    int         exp_busy;
  } vec_t;
  vec_t vecs[5];

  initial begin
    int start;
    int d, n;
    vecs[0] = '{div: 8'd0, tx: 8'hA5, miso_b: 8'hFF, exp_rx: 8'hFF, exp_busy: 19};
    vecs[1] = '{div: 8'd1, tx: 8'h3C, miso_b: 8'h00, exp_rx: 8'h00, exp_busy: 35};
    vecs[2] = '{div: 8'd2, tx: 8'h81, miso_b: 8'h5A, exp_rx: 8'h5A, exp_busy: 51};
    vecs[3] = '{div: 8'd0, tx: 8'h00, miso_b: 8'hC3, exp_rx: 8'hC3, exp_busy: 19};
    vecs[4] = '{div: 8'd3, tx: 8'h7E, miso_b: 8'h96, exp_rx: 8'h96, exp_busy: 67};

    reset = 1'b1;
    divider = 8'd0;
    bus.tx_data = 8'h00;
    bus.tx_write = 1'b0;
    bus.rx_read = 1'b0;
    bus.clear_overflow = 1'b0;
    miso = 1'b0;
    model_ovf = 0;
`ifdef SPI_LOOPBACK_EN
    loopback = 1'b0;
`endif
    repeat (3) @(negedge raw_clk);
    reset = 1'b0;
    @(negedge raw_clk);

    check("reset_sclk", sclk, 1'b0);
    check("reset_mosi", mosi, 1'b0);
    check("reset_overflow", bus.rx_overflow, 1'b0);
    check("reset_rx_data", bus.rx_data, 8'h00);
    check("reset_tx_full", bus.tx_full, 1'b0);
    check("reset_rx_empty", bus.rx_empty, 1'b1);
    check("reset_busy", bus.busy, 1'b0);

    // Single-byte vectors
    for (int i = 0; i < 5; i++) begin
      divider = vecs[i].div;
      miso_src_q.push_back(vecs[i].miso_b);
      exp_q.push_back(vecs[i].tx);
      busy_cycles = 0;
      push(vecs[i].tx);
      wait_idle(5000);
      check("vec_busy_cycles", busy_cycles, vecs[i].exp_busy);
      check_mosi("vec");
      check("vec_rx_empty", bus.rx_empty, 1'b0);
      check("vec_rx_data", bus.rx_data, vecs[i].exp_rx);
      check("vec_mosi_idle", mosi, 1'b0);
      absorb();
      drain();
    end

    // Back-to-back bytes, divider=3, then a read on the empty FIFO
    divider = 8'd3;
    miso_src_q = '{8'h11, 8'h22, 8'h33};
    exp_q = '{8'h3C, 8'hC3, 8'h81};
    busy_cycles = 0;
    push(8'h3C);
    push(8'hC3);
    push(8'h81);
    wait_idle(5000);
    check("b2b_busy_cycles", busy_cycles, 199);
    check_mosi("b2b");
    absorb();
    check("b2b_rx_model_count", rx_model.size(), 3);
    drain();
    bus.rx_read = 1'b1;
    @(negedge raw_clk);
    bus.rx_read = 1'b0;
    @(negedge raw_clk);
    check("empty_read_rx_data_held", bus.rx_data, last_rd);
    check("empty_read_rx_empty", bus.rx_empty, 1'b1);

    // TX full while a slow byte is in flight; 5 received bytes overflow the RX FIFO
    divider = 8'd255;
    miso_src_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
    exp_q = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
    busy_cycles = 0;
    push(8'h10);
    repeat (3) @(negedge raw_clk);
    divider = 8'd0;
    push(8'h20);
    push(8'h30);
    push(8'h40);
    check("tx_full_after_3", bus.tx_full, 1'b0);
    push(8'h50);
    check("tx_full_after_4", bus.tx_full, 1'b1);
    push(8'h60);
    check("tx_full_after_5th", bus.tx_full, 1'b1);
    wait_idle(10000);
    check("stall_busy_cycles", busy_cycles, 1 + 4098 + 4 * 18);
    check_mosi("stall");
    absorb();
    check("overflow_set", bus.rx_overflow, model_ovf);
    pulse_clear();
    model_ovf = 0;
    check("overflow_cleared", bus.rx_overflow, 1'b0);
    drain();

    // RX full: a read in the DONE cycle makes room for the new byte
    divider = 8'd0;
    miso_src_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    push(8'hF0);
    push(8'hF1);
    push(8'hF2);
    push(8'hF3);
    wait_idle(5000);
    absorb();
    mosi_obs_q.delete();
    push(8'hF4);
    wait_high8();
    @(negedge raw_clk);
    check("done_read_rx_data", bus.rx_data, rx_model.pop_front());
    bus.rx_read = 1'b1;
    @(negedge raw_clk);
    bus.rx_read = 1'b0;
    wait_idle(5000);
    absorb();
    check("done_read_no_overflow", bus.rx_overflow, model_ovf);

    // RX full: overflow set and clear_overflow in the same cycle, set wins
    miso_src_q.push_back(8'h06);
    push(8'hF5);
    wait_high8();
    @(negedge raw_clk);
    bus.clear_overflow = 1'b1;
    @(negedge raw_clk);
    bus.clear_overflow = 1'b0;
    wait_idle(5000);
    absorb();
    check("set_wins_overflow", bus.rx_overflow, model_ovf);
    check("set_wins_model", model_ovf, 1'b1);
    drain();
    mosi_obs_q.delete();

    // Reset during bit 4 of the second byte, with overflow still set and TX queued
    divider = 8'd1;
    miso_src_q = '{8'h77, 8'h88, 8'h99};
    push(8'hAA);
    push(8'hBB);
    push(8'hCC);
    start = total_rises;
    for (int k = 0; k < 2000 && total_rises - start < 12; k++) @(negedge raw_clk);
    check("reset_reached_bit4", total_rises - start, 12);
    reset = 1'b1;
    @(negedge raw_clk);
    check("midreset_sclk", sclk, 1'b0);
    check("midreset_mosi", mosi, 1'b0);
    check("midreset_busy", bus.busy, 1'b0);
    check("midreset_rx_empty", bus.rx_empty, 1'b1);
    check("midreset_tx_full", bus.tx_full, 1'b0);
    check("midreset_overflow", bus.rx_overflow, 1'b0);
    check("midreset_rx_data", bus.rx_data, 8'h00);
    reset = 1'b0;
    miso_src_q.delete();
    arrived_q.delete();
    mosi_obs_q.delete();
    rx_model.delete();
    model_ovf = 0;
    repeat (3) @(negedge raw_clk);
    check("after_reset_rx_empty", bus.rx_empty, 1'b1);

    // Randomized bursts against the reference model
    for (int it = 0; it < 20; it++) begin
      d = $urandom_range(0, 3);
      n = $urandom_range(1, DEPTH);
      divider = 8'(d);
      busy_cycles = 0;
      for (int j = 0; j < n; j++) begin
        logic [7:0] tb_b;
        tb_b = 8'($urandom_range(0, 255));
        miso_src_q.push_back(8'($urandom_range(0, 255)));
        exp_q.push_back(tb_b);
      end
      for (int j = 0; j < n; j++) push(exp_q[j]);
      wait_idle(5000);
      check("rand_busy_cycles", busy_cycles, 1 + n * (16 * (d + 1) + 2));
      check_mosi("rand");
      absorb();
      check("rand_overflow", bus.rx_overflow, model_ovf);
      if (model_ovf) begin
        pulse_clear();
        model_ovf = 0;
      end
      if ($urandom_range(0, 1) == 1) drain();
    end
    drain();

`ifdef SPI_LOOPBACK_EN
    loopback = 1'b1;
    divider = 8'd0;
    miso_src_q.push_back(8'h00);
    push(8'h5A);
    wait_idle(5000);
    check("loopback_rx_data", bus.rx_data, 8'h5A);
    arrived_q.delete();
    mosi_obs_q.delete();
    rx_model.push_back(8'h5A);
    drain();
    loopback = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
